// File: rtl/gate_tester.sv
// Stimulus/response engine for a 2-input combinational gate: walks {A,B} through
// 00,01,10,11, samples Y after SETTLE cycles per vector and scores it against TT.
module gate_tester #(
    parameter logic [3:0]  TT     = 4'b0111,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state_q;
    logic [1:0] vec_q;
    logic [3:0] cnt_q;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_count_q;
    logic [3:0] fail_vec_q;

    logic       mismatch_s;
    logic [1:0] vec_inc_s;
    logic [2:0] err_count_d;
    logic [3:0] fail_vec_d;

    // Score of the vector currently applied, folded into the running totals.
    always_comb begin
        mismatch_s  = (Y != TT[vec_q]);
        vec_inc_s   = vec_q + 2'd1;
        err_count_d = err_count_q + {2'b00, mismatch_s};
        fail_vec_d  = fail_vec_q | ({3'b000, mismatch_s} << vec_q);
    end

    // Sequencer: accepts a run, holds each vector for SETTLE cycles, publishes results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 3'd0;
            fail_vec_q  <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        vec_q       <= 2'd0;
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        cnt_q       <= CNT_INIT;
                        err_count_q <= 3'd0;
                        fail_vec_q  <= 4'd0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        err_count_q <= err_count_d;
                        fail_vec_q  <= fail_vec_d;
                        if (vec_q != 2'd3) begin
                            vec_q      <= vec_inc_s;
                            {a_q, b_q} <= vec_inc_s;
                            cnt_q      <= CNT_INIT;
                        end else begin
                            // Verdict includes the vector-3 result scored on this same edge.
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                            pass_q  <= (err_count_d == 3'd0);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_gate_tester.sv
// Scoreboard bench for gate_tester: two instances (SETTLE=2 and SETTLE=1) driving a
// modelled gate whose truth table the stimulus chooses per run.
module tb_gate_tester;

    localparam logic [3:0] TT = 4'b0111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [3:0] gate0, gate1;
    logic       y0, y1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fail0, fail1;

    always #5 clk = ~clk;

    assign y0 = gate0[{a0, b0}];
    assign y1 = gate1[{a1, b1}];

    gate_tester #(.TT(TT), .SETTLE(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .Y(y0),
        .A(a0), .B(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0)
    );

    gate_tester #(.TT(TT), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .Y(y1),
        .A(a1), .B(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    typedef struct {
        int accept;
        int err;
        int fail;
        int pass;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last_exp[2];
    logic prev_done[2] = '{1'b0, 1'b0};
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s inst%0d: got %0d expected %0d at cycle %0d", name, inst, act, exp, cyc);
    endtask

    task automatic mon(input int inst, input int s, input logic a, input logic b,
                       input logic bsy, input logic dn, input logic ps,
                       input logic [2:0] ec, input logic [3:0] fv);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (inst == 0) begin
            if (q0.size() > 0) begin have = 1'b1; e = q0[0]; end
        end else begin
            if (q1.size() > 0) begin have = 1'b1; e = q1[0]; end
        end
        if (have && cyc >= e.accept && cyc < e.accept + 4 * s) begin
            check("vector", inst, int'({a, b}), (cyc - e.accept) / s);
            check("busy_run", inst, int'(bsy), 1);
            check("done_run", inst, int'(dn), 0);
            if (cyc == e.accept) begin
                check("err_cleared", inst, int'(ec), 0);
                check("fail_cleared", inst, int'(fv), 0);
                check("pass_cleared", inst, int'(ps), 0);
            end
        end
        if (dn && !prev_done[inst]) begin
            if (!have) begin
                check("unexpected_done", inst, 1, 0);
            end else begin
                check("done_cycle", inst, cyc, e.accept + 4 * s);
                check("err_count", inst, int'(ec), e.err);
                check("fail_vec", inst, int'(fv), e.fail);
                check("pass", inst, int'(ps), e.pass);
                check("ab_idle", inst, int'({a, b}), 0);
                check("busy_done", inst, int'(bsy), 0);
                last_exp[inst] = e;
                if (inst == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end else if (dn) begin
            check("held_err", inst, int'(ec), last_exp[inst].err);
            check("held_fail", inst, int'(fv), last_exp[inst].fail);
            check("held_pass", inst, int'(ps), last_exp[inst].pass);
        end
        prev_done[inst] = dn;
    endtask

    always @(negedge clk) begin
        mon(0, 2, a0, b0, busy0, done0, pass0, err0, fail0);
        mon(1, 1, a1, b1, busy1, done1, pass1, err1, fail1);
    end

    task automatic check_reset_state(input int inst, input logic a, input logic b,
                                     input logic bsy, input logic dn, input logic ps,
                                     input logic [2:0] ec, input logic [3:0] fv);
        check("rst_ab", inst, int'({a, b}), 0);
        check("rst_busy", inst, int'(bsy), 0);
        check("rst_done", inst, int'(dn), 0);
        check("rst_pass", inst, int'(ps), 0);
        check("rst_err", inst, int'(ec), 0);
        check("rst_fail", inst, int'(fv), 0);
    endtask

    task automatic wait_idle(input int inst);
        int left;
        for (int i = 0; i < 200; i++) begin
            left = (inst == 0) ? q0.size() : q1.size();
            if (left == 0) break;
            @(negedge clk);
        end
        left = (inst == 0) ? q0.size() : q1.size();
        if (left != 0) begin
            check("timeout_pending", inst, left, 0);
            if (inst == 0) q0.delete();
            else q1.delete();
        end
    endtask

    // One start request, held for n back-to-back runs, optional stray pulse mid-run.
    task automatic run(input int inst, input logic [3:0] g, input int n, input int pulse_at);
        int   s;
        int   c;
        exp_t e;
        s = (inst == 0) ? 2 : 1;
        @(negedge clk);
        if (inst == 0) gate0 = g;
        else gate1 = g;
        c = cyc;
        for (int k = 0; k < n; k++) begin
            e.accept = c + 1 + k * (4 * s + 1);
            e.fail   = int'(g ^ TT);
            e.err    = $countones(g ^ TT);
            e.pass   = (e.err == 0) ? 1 : 0;
            if (inst == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (inst == 0) start0 = 1'b1;
        else start1 = 1'b1;
        repeat ((n - 1) * (4 * s + 1) + 1) @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at - 1) @(negedge clk);
            if (inst == 0) start0 = 1'b1;
            else start1 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
        end
        wait_idle(inst);
    endtask

    task automatic reset_mid_run();
        exp_t e;
        @(negedge clk);
        gate0    = TT;
        e.accept = cyc + 1;
        e.err    = 0;
        e.fail   = 0;
        e.pass   = 1;
        q0.push_back(e);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete();
        #1;
        check_reset_state(0, a0, b0, busy0, done0, pass0, err0, fail0);
        check_reset_state(1, a1, b1, busy1, done1, pass1, err1, fail1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int        inst;
        logic [3:0] g;
        int        n;
        int        p;
        rst_n  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        gate0  = TT;
        gate1  = TT;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state(0, a0, b0, busy0, done0, pass0, err0, fail0);
        check_reset_state(1, a1, b1, busy1, done1, pass1, err1, fail1);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 4'b0111, 1, 0);
        run(0, 4'b1000, 1, 0);
        run(0, 4'b1111, 1, 0);
        run(0, 4'b0111, 1, 3);
        run(0, 4'b1000, 1, 0);
        run(0, 4'b0111, 1, 0);
        run(0, 4'b0110, 2, 0);
        reset_mid_run();
        run(0, 4'b0111, 1, 0);
        run(1, 4'b0111, 1, 0);
        run(1, 4'b0001, 3, 0);
        run(1, 4'b0111, 1, 3);

        for (int i = 0; i < 12; i++) begin
            inst = int'($urandom_range(0, 1));
            g    = 4'($urandom_range(0, 15));
            n    = int'($urandom_range(1, 3));
            p    = ($urandom_range(0, 3) == 0) ? 3 : 0;
            run(inst, g, n, p);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
